// File: rtl/mips_hilo_muldiv.sv
// mips_hilo_muldiv: MIPS HI/LO register pair with a multi-cycle multiplier and a restoring divider.
module mips_hilo_muldiv #(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hi_write,
  input  logic                  lo_write,
  input  logic [1:0]            hi_select,
  input  logic [1:0]            lo_select,
  input  logic                  unsigned_mult,
  input  logic                  unsigned_div,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DFIX} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] ma, mb, prod;
  logic [W-1:0] q, d, rem, dividend, q_fix, r_fix;
  logic [W:0] r_shift;
  logic q_neg, r_neg, dz, ge, sa, sb;
  logic mul_op, div_op, mthi, mtlo;
  always_comb begin
    busy       = state != IDLE;
    mul_op     = !busy && hi_write && lo_write && hi_select == 2'b11 && lo_select == 2'b11;
    div_op     = !busy && hi_write && lo_write && hi_select == 2'b10 && lo_select == 2'b10;
    mthi       = !busy && hi_write && hi_select == 2'b01;
    mtlo       = !busy && lo_write && lo_select == 2'b01;
    sa         = !unsigned_div && rs_data[W-1];
    sb         = !unsigned_div && rt_data[W-1];
    prod       = ma * mb;
    r_shift    = {rem, q[W-1]};
    ge         = r_shift >= {1'b0, d};
    q_fix      = q_neg ? -q : q;
    r_fix      = r_neg ? -rem : rem;
    state_next = state;
    if (mul_op) state_next = MUL;
    else if (div_op) state_next = DIV;
    else if (state == MUL && cnt == '0) state_next = IDLE;
    else if (state == DIV && cnt == CW'(W-1)) state_next = DFIX;
    else if (state == DFIX) state_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      q <= '0;
      d <= '0;
      rem <= '0;
      dividend <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz <= 1'b0;
    end else begin
      div_by_zero <= state == DFIX && dz;
      if (mthi) hi <= rs_data;
      if (mtlo) lo <= rs_data;
      if (mul_op) begin
        // Extending to 2W bits lets a plain truncated multiply give the signed or unsigned product
        ma  <= {{W{!unsigned_mult && rs_data[W-1]}}, rs_data};
        mb  <= {{W{!unsigned_mult && rt_data[W-1]}}, rt_data};
        cnt <= CW'(MULT_LATENCY-1);
      end
      if (div_op) begin
        q        <= sa ? -rs_data : rs_data;
        d        <= sb ? -rt_data : rt_data;
        rem      <= '0;
        q_neg    <= sa ^ sb;
        r_neg    <= sa;
        dz       <= rt_data == '0;
        dividend <= rs_data;
        cnt      <= '0;
      end
      if (state == MUL) begin
        if (cnt == '0) {hi, lo} <= prod;
        else cnt <= cnt - 1'b1;
      end
      if (state == DIV) begin
        rem <= ge ? r_shift[W-1:0] - d : r_shift[W-1:0];
        q   <= {q[W-2:0], ge};
        cnt <= cnt + 1'b1;
      end
      if (state == DFIX) begin
        lo <= dz ? '1 : q_fix;
        hi <= dz ? dividend : r_fix;
      end
    end
  end
endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// tb_mips_hilo_muldiv: directed and random checks of HI/LO, multiply and divide against a scoreboard.
module tb_mips_hilo_muldiv;
  logic clk = 0, rst = 1, hi_write = 0, lo_write = 0, unsigned_mult = 0, unsigned_div = 0;
  logic [1:0] hi_select = 0, lo_select = 0;
  logic [31:0] rs_data = 0, rt_data = 0, hi, lo, cur_hi = 0, cur_lo = 0;
  logic busy, div_by_zero;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int lat;} exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mips_hilo_muldiv dut (
    .clk(clk), .rst(rst), .hi_write(hi_write), .lo_write(lo_write),
    .hi_select(hi_select), .lo_select(lo_select), .unsigned_mult(unsigned_mult),
    .unsigned_div(unsigned_div), .rs_data(rs_data), .rt_data(rt_data),
    .hi(hi), .lo(lo), .busy(busy), .div_by_zero(div_by_zero)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_model(bit is_div, bit u, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint p, x, y, qq, rr;
    e.dz = 0;
    e.lat = is_div ? 33 : 2;
    if (!is_div) begin
      p = u ? longint'({32'b0, a}) * longint'({32'b0, b})
            : longint'($signed(a)) * longint'($signed(b));
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.lo = '1;
      e.hi = a;
      e.dz = 1;
    end else if (u) begin
      e.lo = a / b;
      e.hi = a % b;
    end else begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      qq = x / y;
      rr = x % y;
      e.lo = qq[31:0];
      e.hi = rr[31:0];
    end
    sbq.push_back(e);
  endtask

  // Called #1 after an edge; request is accepted at the next edge, returns #1 after completion.
  task automatic do_op(bit is_div, bit u, logic [31:0] a, logic [31:0] b, bit mt_during = 0);
    exp_t e;
    int n;
    push_model(is_div, u, a, b);
    hi_write = 1; lo_write = 1;
    hi_select = is_div ? 2'b10 : 2'b11;
    lo_select = hi_select;
    unsigned_mult = u; unsigned_div = u;
    rs_data = a; rt_data = b;
    @(posedge clk); #1;
    hi_write = 0; lo_write = 0; hi_select = 0; lo_select = 0;
    chk("busy_accept", busy, 1);
    chk("hi_hold_busy", hi, cur_hi);
    if (mt_during) begin
      hi_write = 1; lo_write = 1; hi_select = 2'b01; lo_select = 2'b01;
      rs_data = 32'h12345678;
    end
    n = 1;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    hi_write = 0; lo_write = 0; hi_select = 0; lo_select = 0;
    e = sbq.pop_front();
    chk("busy_cycles", n - 1, e.lat);
    chk("hi", hi, e.hi);
    chk("lo", lo, e.lo);
    chk("dbz", div_by_zero, e.dz);
    cur_hi = e.hi;
    cur_lo = e.lo;
    if (e.dz) begin
      @(posedge clk); #1;
      chk("dbz_pulse_end", div_by_zero, 0);
    end
  endtask

  initial begin
    #2;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    rst = 0;
    do_op(0, 0, 32'hFFFFFFFE, 32'h00000003);
    do_op(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(1, 0, 32'hFFFFFFF9, 32'h00000002);
    do_op(1, 1, 32'd100, 32'd0);
    do_op(1, 0, 32'h80000000, 32'hFFFFFFFF);
    do_op(1, 0, 32'hFFFFFFFB, 32'h00000000);
    do_op(1, 1, 32'hFFFFFFFF, 32'h00000010);
    do_op(0, 0, 32'h80000000, 32'h80000000);
    do_op(1, 0, 32'h0000001F, 32'hFFFFFFFA, 1);
    for (int i = 0; i < 4; i++)
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    hi_write = 1; hi_select = 2'b01; rs_data = 32'h12345678;
    @(posedge clk); #1;
    hi_write = 0; hi_select = 0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, cur_lo);
    cur_hi = 32'h12345678;
    hi_write = 1; lo_write = 1; hi_select = 2'b01; lo_select = 2'b01; rs_data = 32'hA5A5C3C3;
    @(posedge clk); #1;
    chk("mthilo_hi", hi, 32'hA5A5C3C3);
    chk("mthilo_lo", lo, 32'hA5A5C3C3);
    cur_hi = 32'hA5A5C3C3;
    cur_lo = 32'hA5A5C3C3;
    hi_select = 2'b10; lo_select = 2'b11; rs_data = 32'h5;
    @(posedge clk); #1;
    chk("mismatch_busy", busy, 0);
    chk("mismatch_hi", hi, cur_hi);
    chk("mismatch_lo", lo, cur_lo);
    hi_select = 2'b00; lo_select = 2'b00;
    @(posedge clk); #1;
    hi_write = 0; lo_write = 0;
    chk("sel00_busy", busy, 0);
    chk("sel00_hi", hi, cur_hi);
    do_op(0, 1, 32'h00010000, 32'h00010000);
    do_op(1, 0, 32'hFFFFFFF9, 32'h00000002);
    hi_write = 1; lo_write = 1; hi_select = 2'b10; lo_select = 2'b10;
    rs_data = 32'd1000; rt_data = 32'd7; unsigned_div = 1;
    @(posedge clk); #1;
    hi_write = 0; lo_write = 0; hi_select = 0; lo_select = 0;
    repeat (9) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_hold_hi", hi, 0);
    chk("abort_hold_lo", lo, 0);
    chk("abort_hold_busy", busy, 0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
